// File: rtl/pirisc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pirisc_pkg
// Purpose : Shared encodings for the piRISC PC sequencer:
//           - pc_select encodings;
//           - RV32I branch funct3 codes;
//           - PC sequencer FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
package pirisc_pkg;

  // pc_select encodings (5..7 fall back to sequential)
  localparam logic [2:0] PCSEL_SEQ    = 3'd0;
  localparam logic [2:0] PCSEL_BRANCH = 3'd1;
  localparam logic [2:0] PCSEL_JAL    = 3'd2;
  localparam logic [2:0] PCSEL_JALR   = 3'd3;
  localparam logic [2:0] PCSEL_MRET   = 3'd4;

  // RV32I branch funct3 (010/011 are reserved and never taken)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // PC sequencer FSM states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

endpackage : pirisc_pkg
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
// Module  : branch_cmp
// Purpose : Combinational RV32I branch condition evaluator.
// Ports   : branch_op [2:0] - funct3 of the branch instruction
//           rs1_data        - operand A
//           rs2_data        - operand B
//           taken           - 1 when the branch condition holds
// Revision: 1.0 - initial release
// ============================================================================
module branch_cmp
  import pirisc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      branch_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (rs1_data == rs2_data);
  assign w_lt_s = ($signed(rs1_data) < $signed(rs2_data));
  assign w_lt_u = (rs1_data < rs2_data);

  always_comb begin
    taken = 1'b0;
    case (branch_op)
      BR_BEQ:  taken = w_eq;
      BR_BNE:  taken = ~w_eq;
      BR_BLT:  taken = w_lt_s;
      BR_BGE:  taken = ~w_lt_s;
      BR_BLTU: taken = w_lt_u;
      BR_BGEU: taken = ~w_lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule : branch_cmp
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Owns the architectural PC of the piRISC core. Evaluates branch
//           conditions, forms JAL/JALR/MRET targets, enters traps (EPC
//           capture), rejects misaligned targets and runs a BOOT/RUN/HALT FSM.
// Ports   : clk, rst_n (async active-low)
//           pc_en, stall, pc_select, branch_op, rs1_data, rs2_data, imm
//           trap_req, halt_req, resume
//           pc_value, pc_plus4, pc_valid, redirect, epc, misalign_exc, halted
//           perf_redirects, perf_exceptions (only with PC_SEQUENCER_PERF_EN)
// Options : `define PC_SEQUENCER_PERF_EN adds saturating redirect/exception
//           counters.
// Revision: 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pirisc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC   = 'h0000_0100,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic            stall,
  input  logic [2:0]      pc_select,
  input  logic [2:0]      branch_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_value,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            redirect,
  output logic [XLEN-1:0] epc,
  output logic            misalign_exc,
  output logic            halted
`ifdef PC_SEQUENCER_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [15:0]     perf_exceptions
`endif
);

  localparam logic [XLEN-1:0] c_FOUR       = XLEN'(4);
  // Mask of the low bits that must be zero in a legal target
  localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] c_JALR_MASK  = ~XLEN'(1);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_pc_valid;
  logic            r_redirect;
  logic            r_misalign;
  logic            r_halted;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic            w_redirect_nxt;
  logic            w_misalign_nxt;
  logic            w_trap_entry;

  logic            w_taken;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_nonseq;
  logic            w_misaligned;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_branch_cmp (
    .branch_op (branch_op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .taken     (w_taken)
  );

  assign w_pc_plus4 = r_pc + c_FOUR;
  assign w_pc_imm   = r_pc + imm;
  assign w_jalr_sum = rs1_data + imm;

  // Target selection; w_nonseq marks the updates that break sequential flow
  always_comb begin
    w_target = w_pc_plus4;
    w_nonseq = 1'b0;
    case (pc_select)
      PCSEL_BRANCH: begin
        w_target = w_taken ? w_pc_imm : w_pc_plus4;
        w_nonseq = w_taken;
      end
      PCSEL_JAL: begin
        w_target = w_pc_imm;
        w_nonseq = 1'b1;
      end
      PCSEL_JALR: begin
        w_target = w_jalr_sum & c_JALR_MASK;
        w_nonseq = 1'b1;
      end
      PCSEL_MRET: begin
        w_target = r_epc;
        w_nonseq = 1'b1;
      end
      default: begin
        w_target = w_pc_plus4;
        w_nonseq = 1'b0;
      end
    endcase
  end

  assign w_misaligned = ((w_target & c_ALIGN_MASK) != '0);

  // Next-state / next-PC logic
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_redirect_nxt = 1'b0;
    w_misalign_nxt = 1'b0;
    w_trap_entry   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (trap_req) begin
          w_trap_entry   = 1'b1;
          w_epc_nxt      = r_pc;
          w_pc_nxt       = TRAP_VEC;
          w_redirect_nxt = 1'b1;
        end else if (halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (!stall && pc_en) begin
          if (w_misaligned) begin
            w_epc_nxt      = r_pc;
            w_pc_nxt       = TRAP_VEC;
            w_misalign_nxt = 1'b1;
            w_redirect_nxt = 1'b1;
          end else begin
            w_pc_nxt       = w_target;
            w_redirect_nxt = w_nonseq;
          end
        end
      end
      ST_HALT: begin
        if (trap_req) begin
          w_trap_entry   = 1'b1;
          w_epc_nxt      = r_pc;
          w_pc_nxt       = TRAP_VEC;
          w_redirect_nxt = 1'b1;
          w_state_nxt    = ST_RUN;
        end else if (resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_epc      <= '0;
      r_pc_valid <= 1'b0;
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_epc      <= w_epc_nxt;
      r_pc_valid <= (w_state_nxt == ST_RUN);
      r_redirect <= w_redirect_nxt;
      r_misalign <= w_misalign_nxt;
      r_halted   <= (w_state_nxt == ST_HALT);
    end
  end

  assign pc_value     = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign pc_valid     = r_pc_valid;
  assign redirect     = r_redirect;
  assign epc          = r_epc;
  assign misalign_exc = r_misalign;
  assign halted       = r_halted;

`ifdef PC_SEQUENCER_PERF_EN
  logic [31:0] r_perf_redirects;
  logic [15:0] r_perf_exceptions;

  // Counters advance on the same edge that registers the pulse they count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_redirects  <= '0;
      r_perf_exceptions <= '0;
    end else begin
      if (w_redirect_nxt && (r_perf_redirects != '1)) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
      if ((w_misalign_nxt || w_trap_entry) && (r_perf_exceptions != '1)) begin
        r_perf_exceptions <= r_perf_exceptions + 16'd1;
      end
    end
  end

  assign perf_redirects  = r_perf_redirects;
  assign perf_exceptions = r_perf_exceptions;
`endif

endmodule : pc_sequencer
`default_nettype wire
